riscv_multicycle_control: RTL
=============================

Name: riscv_multicycle_control

Overview:
- Multicycle control FSM for the RISC-V core. It is the successor to the single-cycle combinational decoder.
- It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared memory and ALU, and supports parametrised memory wait states and multi-cycle MUL.
- It drives PC, IR, register-file, memory and ALU mux controls, and raises a sticky illegal-instruction flag.

Parameters:
- MEM_LATENCY, 0: extra wait cycles per memory access; each access state lasts MEM_LATENCY+1 cycles.
- MUL_LATENCY, 2: cycles spent in MULWAIT; range 1..15.
- ENABLE_MUL, 1: when 0, funct7=0000001 R-type is illegal.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- Funct3  in  3  IR[14:12].
- Funct7  in  7  IR[31:25].
- zero  in  1  ALU zero flag, current cycle.
- PCWrite  out  1  PC register load.
- IRWrite  out  1  IR and OldPC load.
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register-file write.
- ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ALU result.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  00=rs2, 01=imm, 10=const 4.
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- ALUOp  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0110 SLT, 0111 MUL, 1000 XOR, 1001 SRA, 1010 SLTU.
- Illegal  out  1  sticky illegal-instruction flag.
- state_o  out  4  current state encoding, for debug.

Behaviour:

Supported opcodes:
- 33 R-type, 13 I-ALU, 03 LW, 23 SW, 63 branch, 6F JAL, 67 JALR, 17 AUIPC.
- Any other opcode goes to TRAP.

Reset:
- State becomes FETCH, wait counter becomes 0, Illegal becomes 0.
- While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Reset mid-instruction aborts the instruction with no further writes.

Defaults:
- Any output not listed for a state is 0, except ALUOp, which defaults to ADD.

Wait counter:
- Loaded with MEM_LATENCY on entry to FETCH, MEMREAD or MEMWRITE; decrements each cycle.
- The state exits when the counter reaches 0. With MEM_LATENCY=0 the state lasts exactly 1 cycle.
- The same counter is loaded with MUL_LATENCY-1 on entry to MULWAIT.

States:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. On the final cycle only: IRWrite=1, PCWrite=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc per opcode; ALUOut latches OldPC+imm. Next state by opcode:
  - R -> EXECUTER
  - I -> EXECUTEI
  - LW/SW -> MEMADR
  - branch -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - AUIPC -> ALUWB
  - else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000 (LW) or 001 (SW). Next: MEMREAD or MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB after the wait.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 on every cycle of the access. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00.
  - ALUOp from Funct7/Funct3: 0100000+000 SUB, 0100000+101 SRA, 0000001 MUL, otherwise by Funct3 (000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND).
  - Next: MULWAIT if MUL; TRAP if MUL with ENABLE_MUL=0 or funct7 is unlisted; else ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. ALUOp by Funct3 as above; Funct3=101 with IR[30]=Funct7[5]=1 gives SRA. Next: ALUWB.
- MULWAIT: holds EXECUTER mux settings with ALUOp=MUL for MUL_LATENCY cycles. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=SUB, ResultSrc=00, ImmSrc=010.
  - PCWrite = zero if Funct3=000; !zero if Funct3=001; 0 for other Funct3. PCWrite is Mealy on zero.
  - Next: FETCH.
- JAL: ResultSrc=00, PCWrite=1; ALUSrcA=01, ALUSrcB=10, ADD, so ALUOut latches OldPC+4. Next: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ADD, ResultSrc=10, PCWrite=1. Next: LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, ADD. Next: ALUWB.
- TRAP:
  - Illegal=1 (sticky until reset).
  - All strobes 0; the state is absorbing until reset.

Test Plan:
- MEM_LATENCY=0, ADD (33, f3=000, f7=00) -> FETCH,DECODE,EXECUTER,ALUWB in 4 cycles; ALUOp=0010 in EXECUTER; RegWrite=1 only in cycle 4.
- MEM_LATENCY=2, LW (03) -> FETCH 3 cycles with IRWrite/PCWrite on cycle 3 only; MEMREAD 3 cycles with AdrSrc=1; MEMWB RegWrite=1, ResultSrc=01; 9 cycles total.
- BEQ with zero=1 -> PCWrite=1 in BRANCH; BNE with zero=1 -> PCWrite=0; Funct3=100 -> PCWrite=0; each returns to FETCH.
- MUL (f7=0000001), MUL_LATENCY=3 -> EXECUTER, then 3 MULWAIT cycles with ALUOp=0111, then ALUWB; 7 cycles total. With ENABLE_MUL=0 -> TRAP and Illegal=1.
- JALR -> PCWrite=1 with ResultSrc=10 in JALR; LINK with ALUSrcA=01, ALUSrcB=10; RegWrite in ALUWB; opcode 7F -> Illegal stays 1 until reset.
- SW with MEM_LATENCY=1, reset asserted in the second MEMWRITE cycle -> MemWrite=0 during reset; state FETCH next cycle; Illegal=0.

Source files
------------

// File: rtl/riscv_multicycle_control.sv
`timescale 1ns/1ps
// riscv_multicycle_control
//   Multicycle control FSM for the RISC-V core. It sequences fetch, decode,
//   execute, memory and writeback over a shared memory and ALU. It supports
//   memory wait states and a multi-cycle multiplier.
//
// Parameters
//   MEM_LATENCY : extra wait cycles per memory access (FETCH/MEMREAD/MEMWRITE)
//   MUL_LATENCY : cycles spent in MULWAIT (1..15)
//   ENABLE_MUL  : 0 makes funct7=0000001 R-type instructions illegal
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   opcode/Funct3/Funct7 : instruction fields from IR
//   zero              : ALU zero flag, used combinationally in BRANCH
//   PCWrite, IRWrite, MemWrite, RegWrite : write strobes (gated off in reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp : datapath mux controls
//   Illegal           : sticky illegal-instruction flag
//   state_o           : current state encoding for debug
module riscv_multicycle_control #(
  parameter int MEM_LATENCY = 0,
  parameter int MUL_LATENCY = 2,
  parameter bit ENABLE_MUL  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_MULWAIT  = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_LINK     = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LW    = 7'h03;
  localparam logic [6:0] OP_SW    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_MUL  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [3:0] MEM_LIM = 4'(MEM_LATENCY);
  localparam logic [3:0] MUL_LIM = 4'(MUL_LATENCY - 1);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [3:0] wait_cnt;
  logic       wait_done;
  logic       illegal_q;

  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;

  logic       r_is_mul;
  logic       r_is_alt;
  logic       r_legal;
  logic [3:0] r_aluop;
  logic [3:0] i_aluop;
  logic [2:0] decode_imm;

  // Shared ALU operation table indexed by funct3; alt selects SRA for 101.
  function automatic logic [3:0] alu_by_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    r_is_mul = (Funct7 == F7_MUL);
    r_is_alt = (Funct7 == F7_ALT);
    r_legal  = (Funct7 == F7_BASE) || r_is_alt || (r_is_mul && ENABLE_MUL);
    if (r_is_mul)
      r_aluop = ALU_MUL;
    else if (r_is_alt && (Funct3 == 3'b000))
      r_aluop = ALU_SUB;
    else
      r_aluop = alu_by_funct3(Funct3, r_is_alt);
    i_aluop = alu_by_funct3(Funct3, Funct7[5]);
    case (opcode)
      OP_SW:    decode_imm = 3'b001;
      OP_BR:    decode_imm = 3'b010;
      OP_JAL:   decode_imm = 3'b011;
      OP_AUIPC: decode_imm = 3'b100;
      default:  decode_imm = 3'b000;
    endcase
  end

  // wait_cnt counts cycles already spent in the current state, starting at 0
  // on every state change, so each wait state ends once it reaches its limit.
  always_comb begin
    case (state)
      S_FETCH, S_MEMREAD, S_MEMWRITE: wait_done = (wait_cnt == MEM_LIM);
      S_MULWAIT:                      wait_done = (wait_cnt == MUL_LIM);
      default:                        wait_done = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (wait_done) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:          state_next = S_EXECUTER;
          OP_I:          state_next = S_EXECUTEI;
          OP_LW, OP_SW:  state_next = S_MEMADR;
          OP_BR:         state_next = S_BRANCH;
          OP_JAL:        state_next = S_JAL;
          OP_JALR:       state_next = S_JALR;
          OP_AUIPC:      state_next = S_ALUWB;
          default:       state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (wait_done) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (wait_done) state_next = S_FETCH;
      S_EXECUTER: begin
        if (!r_legal)
          state_next = S_TRAP;
        else if (r_is_mul)
          state_next = S_MULWAIT;
        else
          state_next = S_ALUWB;
      end
      S_EXECUTEI: state_next = S_ALUWB;
      S_MULWAIT:  if (wait_done) state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_JALR:     state_next = S_LINK;
      S_LINK:     state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    ALUOp     = ALU_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_write  = wait_done;
        ir_write  = wait_done;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = decode_imm;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_SW) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = r_aluop;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = i_aluop;
      end
      S_MULWAIT: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALU_MUL;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALU_SUB;
        ImmSrc  = 3'b010;
        // Mealy on zero: the compare result is only valid in this cycle.
        case (Funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = !zero;
          default: pc_write = 1'b0;
        endcase
      end
      S_JAL: begin
        pc_write = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed during reset so an aborted instruction cannot
  // commit anything in the cycle reset is sampled.
  assign PCWrite  = pc_write  && !reset;
  assign IRWrite  = ir_write  && !reset;
  assign MemWrite = mem_write && !reset;
  assign RegWrite = reg_write && !reset;
  assign Illegal  = illegal_q;
  assign state_o  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state_next != state) ? 4'd0 : wait_cnt + 4'd1;
      if (state_next == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

endmodule
